// File: rtl/semi_serial_layer.sv
// Fully-connected layer of M neurons, K parallel MAC lanes per neuron, with
// bias/lane-reduce, saturation and ReLU/linear activation per neuron output.
module semi_serial_layer #(
   parameter int N  = 4,
   parameter int M  = 3,
   parameter int K  = 2,
   parameter int QM = 12,
   parameter int QN = 20,
   parameter int WM = 6,
   parameter int WN = 10
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic                        act_sel,
   input  logic signed [QM+QN-1:0]     in [N],
   input  logic signed [WM+WN-1:0]     weights [M][N],
   input  logic signed [QM+QN-1:0]     bias [M],
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic signed [QM+QN-1:0]     out_data,
   output logic [$clog2(M):0]          out_idx,
   output logic                        out_last,
   output logic                        out_sat
);

   localparam int DW  = QM + QN;
   localparam int WW  = WM + WN;
   localparam int PW  = DW + WW;
   localparam int AW  = PW + $clog2(N + 1) + 1;
   localparam int P   = (N + K - 1) / K;
   localparam int PCW = (P > 1) ? $clog2(P) : 1;
   localparam int JW  = $clog2(M) + 1;
   localparam int JIW = (M > 1) ? $clog2(M) : 1;
   localparam int IW  = (N > 1) ? $clog2(N) : 1;

   localparam logic signed [AW-1:0] DMAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [AW-1:0] DMIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_MAC, S_REDUCE, S_ACT, S_OUT} state_t;

   state_t                 state_q;
   logic                   in_ready_q;
   logic                   act_q;
   logic [PCW-1:0]         p_q;
   logic [JW-1:0]          j_q;
   logic signed [DW-1:0]   in_q [N];
   logic signed [WW-1:0]   w_q [M][N];
   logic signed [DW-1:0]   b_q [M];
   logic signed [AW-1:0]   acc_q [K];
   logic signed [AW-1:0]   sum_q;
   logic                   out_valid_q;
   logic signed [DW-1:0]   out_data_q;
   logic [JW-1:0]          out_idx_q;
   logic                   out_last_q;
   logic                   out_sat_q;

   logic signed [PW-1:0]   mul_d [K];
   logic signed [AW-1:0]   sum_d;

   // Scale back to output format, clamp to the signed output range, then activate.
   function automatic logic [DW:0] sat_act(input logic signed [AW-1:0] s, input logic lin);
      logic signed [AW-1:0] r;
      logic signed [DW-1:0] y;
      logic                 sat;
      r   = s >>> WN;
      sat = 1'b0;
      if (r > DMAX) begin
         y   = DMAX[DW-1:0];
         sat = 1'b1;
      end else if (r < DMIN) begin
         y   = DMIN[DW-1:0];
         sat = 1'b1;
      end else begin
         y = r[DW-1:0];
      end
      if (!lin && y[DW-1]) y = '0;
      return {sat, y};
   endfunction

   // Lane k handles element p*K+k; lanes past the end of the vector contribute zero.
   always_comb begin
      for (int k = 0; k < K; k++) begin
         mul_d[k] = '0;
         if (int'(p_q) * K + k < N)
            mul_d[k] = PW'(in_q[IW'(int'(p_q) * K + k)])
                     * PW'(w_q[JIW'(j_q)][IW'(int'(p_q) * K + k)]);
      end
   end

   always_comb begin
      sum_d = AW'(b_q[JIW'(j_q)]) <<< WN;
      for (int k = 0; k < K; k++) sum_d = sum_d + acc_q[k];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         in_ready_q  <= 1'b1;
         act_q       <= 1'b0;
         p_q         <= '0;
         j_q         <= '0;
         in_q        <= '{default: '0};
         w_q         <= '{default: '{default: '0}};
         b_q         <= '{default: '0};
         acc_q       <= '{default: '0};
         sum_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
         out_sat_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid && in_ready_q) begin
                  in_q       <= in;
                  w_q        <= weights;
                  b_q        <= bias;
                  act_q      <= act_sel;
                  in_ready_q <= 1'b0;
                  j_q        <= '0;
                  p_q        <= '0;
                  acc_q      <= '{default: '0};
                  state_q    <= S_MAC;
               end
            end
            S_MAC: begin
               for (int k = 0; k < K; k++) acc_q[k] <= acc_q[k] + AW'(mul_d[k]);
               if (p_q == PCW'(P - 1)) begin
                  p_q     <= '0;
                  state_q <= S_REDUCE;
               end else begin
                  p_q <= p_q + 1'b1;
               end
            end
            S_REDUCE: begin
               sum_q   <= sum_d;
               state_q <= S_ACT;
            end
            S_ACT: begin
               {out_sat_q, out_data_q} <= sat_act(sum_q, act_q);
               out_idx_q   <= j_q;
               out_last_q  <= (j_q == JW'(M - 1));
               out_valid_q <= 1'b1;
               state_q     <= S_OUT;
            end
            S_OUT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  j_q         <= j_q + 1'b1;
                  if (j_q == JW'(M - 1)) begin
                     in_ready_q <= 1'b1;
                     state_q    <= S_IDLE;
                  end else begin
                     p_q     <= '0;
                     acc_q   <= '{default: '0};
                     state_q <= S_MAC;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;
   assign out_last  = out_last_q;
   assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_semi_serial_layer.sv
// Directed bench for semi_serial_layer with N=5, M=3, K=2 (P=3, one padded lane slot).
module tb_semi_serial_layer;

   localparam int N = 5;
   localparam int M = 3;
   localparam int K = 2;
   localparam int DW = 32;
   localparam int WW = 16;
   localparam int LAT = 5;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 in_valid;
   logic                 in_ready;
   logic                 act_sel;
   logic signed [DW-1:0] in_v [N];
   logic signed [WW-1:0] w_v [M][N];
   logic signed [DW-1:0] b_v [M];
   logic                 out_valid;
   logic                 out_ready;
   logic signed [DW-1:0] out_data;
   logic [2:0]           out_idx;
   logic                 out_last;
   logic                 out_sat;

   int   n_chk  = 0;
   int   n_pass = 0;
   int   n_fail = 0;
   logic hold_ready = 1'b0;

   semi_serial_layer #(.N(N), .M(M), .K(K)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .act_sel   (act_sel),
      .in        (in_v),
      .weights   (w_v),
      .bias      (b_v),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .out_sat   (out_sat)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp_v);
      n_chk++;
      assert (obs === exp_v) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic set_in(input longint a0, a1, a2, a3, a4);
      in_v[0] = DW'(a0); in_v[1] = DW'(a1); in_v[2] = DW'(a2);
      in_v[3] = DW'(a3); in_v[4] = DW'(a4);
   endtask

   task automatic set_w(input int j, input longint a0, a1, a2, a3, a4, input longint b);
      w_v[j][0] = WW'(a0); w_v[j][1] = WW'(a1); w_v[j][2] = WW'(a2);
      w_v[j][3] = WW'(a3); w_v[j][4] = WW'(a4);
      b_v[j] = DW'(b);
   endtask

   task automatic start_job(input logic a);
      @(negedge clk);
      in_valid = 1'b1;
      act_sel  = a;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      act_sel  = ~a;
      chk("accept.in_ready", in_ready, 0);
   endtask

   task automatic expect_out(input string tag, input int idx, input longint data,
                             input logic last, input logic sat);
      int n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!out_valid && n < 40);
      chk({tag, ".lat"}, n, LAT);
      chk({tag, ".idx"}, out_idx, idx);
      chk({tag, ".data"}, out_data, data);
      chk({tag, ".last"}, out_last, last);
      chk({tag, ".sat"}, out_sat, sat);
      chk({tag, ".in_ready"}, in_ready, 0);
   endtask

   task automatic handshake(input string tag, input logic last);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = hold_ready;
      chk({tag, ".valid_drop"}, out_valid, 0);
      chk({tag, ".in_ready_after"}, in_ready, last);
   endtask

   task automatic job_a_weights();
      set_w(0, 512, 256, 0, 0, 0, 262144);
      set_w(1, -1024, -1024, 0, 0, 0, 0);
      set_w(2, 0, 0, 1024, 0, 1024, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      act_sel   = 1'b0;
      out_ready = 1'b0;
      set_in(0, 0, 0, 0, 0);
      for (int j = 0; j < M; j++) set_w(j, 0, 0, 0, 0, 0, 0);
      #12;
      chk("rst.in_ready", in_ready, 1);
      chk("rst.out_valid", out_valid, 0);
      chk("rst.out_data", out_data, 0);
      chk("rst.out_idx", out_idx, 0);
      chk("rst.out_last", out_last, 0);
      chk("rst.out_sat", out_sat, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Job A, ReLU: 1.25, relu(-3.0)=0, 2.0; held output under backpressure
      set_in(1048576, 2097152, -1048576, 524288, 3145728);
      job_a_weights();
      start_job(1'b0);
      set_in(0, 0, 0, 0, 0);
      expect_out("A0", 0, 1310720, 0, 0);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         chk("bp.valid", out_valid, 1);
         chk("bp.data", out_data, 1310720);
         chk("bp.idx", out_idx, 0);
         chk("bp.in_ready", in_ready, 0);
         in_valid = (i == 3);
         act_sel  = 1'b1;
      end
      in_valid = 1'b0;
      handshake("A0", 0);
      in_valid = 1'b1;
      act_sel  = 1'b1;
      expect_out("A1", 1, 0, 0, 0);
      handshake("A1", 0);
      in_valid = 1'b0;
      expect_out("A2", 2, 2097152, 1, 0);
      handshake("A2", 1);

      // Job B, linear; reset during neuron 1 MAC abandons the job
      set_in(1048576, 2097152, -1048576, 524288, 3145728);
      start_job(1'b1);
      expect_out("B0", 0, 1310720, 0, 0);
      handshake("B0", 0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst.out_valid", out_valid, 0);
      chk("midrst.in_ready", in_ready, 1);
      chk("midrst.out_data", out_data, 0);
      chk("midrst.out_idx", out_idx, 0);
      @(negedge clk);
      rst_n = 1'b1;
      start_job(1'b1);
      expect_out("B0r", 0, 1310720, 0, 0);
      handshake("B0r", 0);
      expect_out("B1r", 1, -3145728, 0, 0);
      handshake("B1r", 0);
      expect_out("B2r", 2, 2097152, 1, 0);
      handshake("B2r", 1);

      // Job C, linear, out_ready held high: floor truncation and bias alignment
      hold_ready = 1'b1;
      out_ready  = 1'b1;
      set_in(1, 1, 1, 1, 1);
      set_w(0, -1, 0, 0, 0, 0, 0);
      set_w(1, 1, 0, 0, 0, 0, 0);
      set_w(2, 1024, 1024, 1024, 1024, 1024, 7);
      start_job(1'b1);
      expect_out("C0", 0, -1, 0, 0);
      handshake("C0", 0);
      expect_out("C1", 1, 0, 0, 0);
      handshake("C1", 0);
      expect_out("C2", 2, 12, 1, 0);
      handshake("C2", 1);
      hold_ready = 1'b0;
      out_ready  = 1'b0;

      // Jobs D/E: full-scale saturation, linear then ReLU
      set_in(2147483647, 2147483647, 2147483647, 2147483647, 2147483647);
      set_w(0, 32767, 32767, 32767, 32767, 32767, 0);
      set_w(1, -32768, -32768, -32768, -32768, -32768, 0);
      set_w(2, 0, 0, 0, 0, 0, -5);
      start_job(1'b1);
      expect_out("D0", 0, 2147483647, 0, 1);
      handshake("D0", 0);
      expect_out("D1", 1, -(64'sd2147483648), 0, 1);
      handshake("D1", 0);
      expect_out("D2", 2, -5, 1, 0);
      handshake("D2", 1);
      start_job(1'b0);
      expect_out("E0", 0, 2147483647, 0, 1);
      handshake("E0", 0);
      expect_out("E1", 1, 0, 0, 1);
      handshake("E1", 0);
      expect_out("E2", 2, 0, 1, 0);
      handshake("E2", 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
